// File: rtl/pc_fetch_seq_if.sv
// Fetch-sequencer bus bundle: imem request/ack, decode valid/ready and branch redirect.
// Optional trap/epc signals exist only when PC_TRAP_EN is defined.
interface pc_fetch_seq_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            branch;
    logic            ZERO;
    logic [XLEN-1:0] tar_inst;
    logic [XLEN-1:0] pc_cur;
`ifdef PC_TRAP_EN
    logic            trap;
    logic [XLEN-1:0] epc;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready, branch, ZERO, tar_inst,
`ifdef PC_TRAP_EN
        input  trap,
        output epc,
`endif
        output pc_cur
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready, branch, ZERO, tar_inst,
`ifdef PC_TRAP_EN
        output trap,
        input  epc,
`endif
        input  pc_cur
    );
endinterface

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the word-addressed PC, issues imem fetches, holds one instruction for decode.
// Define PC_TRAP_EN to add the trap input / epc output with trap-over-branch priority.
module pc_fetch_seq #(
    parameter int              XLEN     = 32,
`ifdef PC_TRAP_EN
    parameter logic [XLEN-1:0] TRAP_VEC = 'h10,
`endif
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    pc_fetch_seq_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [31:0]     inst, inst_nxt;
    logic [XLEN-1:0] inst_pc, inst_pc_nxt;
    logic            redirect;
`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc, epc_nxt;
`endif

    assign redirect = bus.branch && bus.ZERO;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            inst_pc <= '0;
`ifdef PC_TRAP_EN
            epc     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            inst    <= inst_nxt;
            inst_pc <= inst_pc_nxt;
`ifdef PC_TRAP_EN
            epc     <= epc_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
`ifdef PC_TRAP_EN
        epc_nxt     = epc;
`endif
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) pc_nxt = bus.tar_inst;
            end
            REQ: begin
                // A redirect wins over a same-cycle ack, so that fetched word is dropped.
                if (redirect) begin
                    pc_nxt    = bus.tar_inst;
                    state_nxt = FLUSH;
                end else if (bus.imem_ack) begin
                    inst_nxt    = bus.imem_rdata;
                    inst_pc_nxt = pc;
                    pc_nxt      = pc + XLEN'(1);
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = bus.tar_inst;
                    state_nxt = FLUSH;
                end else if (bus.inst_ready) begin
                    state_nxt = REQ;
                end
            end
            FLUSH:   state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
`ifdef PC_TRAP_EN
        if (bus.trap) begin
            epc_nxt     = (state == HOLD) ? inst_pc : pc;
            pc_nxt      = TRAP_VEC;
            inst_nxt    = inst;
            inst_pc_nxt = inst_pc;
            state_nxt   = (state == IDLE) ? REQ : FLUSH;
        end
`endif
    end

    assign bus.imem_req   = (state == REQ);
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = (state == HOLD);
    assign bus.inst       = inst;
    assign bus.inst_pc    = inst_pc;
    assign bus.pc_cur     = pc;
`ifdef PC_TRAP_EN
    assign bus.epc        = epc;
`endif

endmodule
